pump_sequencer: RTL and testbench
=================================

# pump_sequencer

Clocked pump sequencer for the water-level system, replacing ad-hoc combinational pump control with filtered, time-qualified sequencing. Debounces the three level sensors and runs the pump through a state machine. The state machine enforces a minimum off time, a maximum run time (dry-run/overflow guard) and sensor-consistency checking. Sits between the raw float-switch inputs and the pump relay driver.

## Interface

- DEBOUNCE_CYC, 16, consecutive cycles a synchronized sensor must disagree with its filtered value before the filtered value flips (≥1)
- MIN_OFF_CYC, 64, cycles spent in HOLDOFF after every stop and after reset (≥1)
- MAX_RUN_CYC, 1024, maximum continuous cycles in RUN before TIMEOUT fault (≥2)
- CNT_W, 16, width of holdoff/run counters; must hold MAX_RUN_CYC and MIN_OFF_CYC
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ug_ll  in  1  underground tank low-level switch, async; 1 = source has water
- uh_hl  in  1  overhead tank high-level switch, async; 1 = overhead full
- uh_ll  in  1  overhead tank low-level switch, async; 0 = overhead below low mark
- enable  in  1  1 = automatic pumping permitted
- fault_clr  in  1  single-cycle pulse; leaves FAULT
- pump  out  1  pump relay drive, registered
- fault  out  1  1 while in FAULT
- fault_code  out  2  00 none, 01 TIMEOUT, 10 SENSOR; held until fault_clr
- state  out  3  current FSM state encoding, for status display

## Operation

- Each sensor: 2-flop synchronizer, then debounce counter. The counter increments on every edge at which the synchronized value ≠ filtered value, and clears on any agreeing edge. The filtered value flips on the DEBOUNCE_CYC-th consecutive differing edge, and the counter then clears.
- Filtered values reset to 0. Because a filtered ug_ll of 0 blocks RUN, the pump stays off until real sensor data arrives.
- States: HOLDOFF, IDLE, RUN, FAULT. Reset → HOLDOFF with holdoff counter 0 and run counter 0.
- HOLDOFF: pump 0. The counter increments each cycle. The FSM moves to IDLE on the edge ending the MIN_OFF_CYC-th cycle.
- IDLE: pump 0. The FSM moves to RUN when enable && f_ug_ll && !f_uh_ll. Otherwise it stays in IDLE.
- RUN: pump 1. The run counter clears on entry and increments each RUN cycle. Exit priority, highest first:
  - SENSOR conflict → FAULT
  - run count reaching MAX_RUN_CYC → FAULT, code 01
  - f_uh_hl → HOLDOFF
  - !f_ug_ll → HOLDOFF
  - !enable → HOLDOFF
- Sensor conflict is f_uh_hl=1 && f_uh_ll=0, i.e. high wet, low dry. From any non-FAULT state it forces FAULT with code 10.
- FAULT: pump 0, fault 1, code held. fault_clr → HOLDOFF with code cleared to 00. If the conflict persists, FAULT is re-entered from HOLDOFF on the next edge.
- fault_clr outside FAULT is ignored. Simultaneous conflict and timeout records code 10.

## Timing

- Reset values: pump 0, fault 0, fault_code 00, state=HOLDOFF, all filtered sensors 0, all counters 0.
- Raw sensor change (held stable) → filtered flip: DEBOUNCE_CYC+2 edges. Filtered flip → state/pump change: 1 edge. Total raw → pump latency is DEBOUNCE_CYC+3 edges.
- pump is decoded from the registered state, so it changes on the same edge as the state transition.
- Minimum pump-off time is MIN_OFF_CYC+1 cycles. Maximum continuous pump-on time is exactly MAX_RUN_CYC cycles.
- Reset asserted mid-RUN: pump 0 after that edge, and the sequence restarts from HOLDOFF.

## Structure

- Shared package pump_pkg holds:
  - state enum (HOLDOFF=0, IDLE=1, RUN=2, FAULT=3)
  - fault_code constants (FC_NONE, FC_TIMEOUT, FC_SENSOR)
- Sub-module level_debounce (parameter DEBOUNCE_CYC) is instantiated three times. It contains the synchronizer, counter and filtered register.
- The top level contains the FSM, holdoff counter and run counter.

## Test plan

Parameters DEBOUNCE_CYC=4, MIN_OFF_CYC=8, MAX_RUN_CYC=32; edges counted from reset release.

- Startup: reset release with ug_ll=1, uh_ll=0, uh_hl=0, enable=1 → pump 0 through edge 8, IDLE at edge 8, pump 1 from edge 9, fault 0.
- Normal stop: in RUN, drive uh_ll=1, then uh_hl=1 → pump falls exactly 7 edges after uh_hl rises. Pump stays 0 for ≥9 cycles even though uh_hl later returns to 0 with uh_ll=0.
- Glitch rejection: in RUN, pulse uh_hl=1 for 3 cycles → pump stays 1 and state stays RUN.
- Timeout: hold uh_hl=0, uh_ll=0 → pump 1 for exactly 32 cycles, then fault=1, fault_code=01. A fault_clr pulse gives fault 0, code 00, state HOLDOFF, and pump 1 again 9 edges later.
- Sensor conflict: drive uh_hl=1, uh_ll=0 from IDLE → FAULT with code 10, pump 0. fault_clr while the conflict is held → HOLDOFF for 1 cycle, then FAULT again.
- Source dry and reset: ug_ll→0 in RUN → pump 0 after 7 edges with fault 0. Separately, rst pulsed mid-RUN → pump 0 after that edge and all outputs at reset values.

Source files
------------

// File: rtl/pump_pkg.sv
// Shared types and constants for the water-level pump sequencer.
// State encoding is visible on the status output, so values are fixed here.
package pump_pkg;

    typedef enum logic [2:0] {
        HOLDOFF = 3'd0,
        IDLE    = 3'd1,
        RUN     = 3'd2,
        FAULT   = 3'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_SENSOR  = 2'b10;

    // High switch wet while the low switch is dry cannot happen with healthy floats.
    function automatic logic sensor_conflict(input logic f_uh_hl, input logic f_uh_ll);
        return f_uh_hl & ~f_uh_ll;
    endfunction

endpackage

// File: rtl/level_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement debounce filter
// for one float switch. The filtered level resets to 0.
module level_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // The counter tracks how many edges in a row sync_b has differed from filt;
    // any agreeing edge restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b != filt) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    filt <= sync_b;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pump_sequencer.sv
// Pump sequencer: debounced level sensors drive a HOLDOFF/IDLE/RUN/FAULT machine
// enforcing minimum off time, maximum run time and sensor consistency.
module pump_sequencer
    import pump_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int MIN_OFF_CYC  = 64,
    parameter int MAX_RUN_CYC  = 1024,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ug_ll,
    input  logic       uh_hl,
    input  logic       uh_ll,
    input  logic       enable,
    input  logic       fault_clr,
    output logic       pump,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    logic f_ug_ll;
    logic f_uh_hl;
    logic f_uh_ll;

    level_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ug_ll (
        .clk  (clk),
        .rst  (rst),
        .raw  (ug_ll),
        .filt (f_ug_ll)
    );

    level_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_uh_hl (
        .clk  (clk),
        .rst  (rst),
        .raw  (uh_hl),
        .filt (f_uh_hl)
    );

    level_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_uh_ll (
        .clk  (clk),
        .rst  (rst),
        .raw  (uh_ll),
        .filt (f_uh_ll)
    );

    state_t             state_r;
    state_t             state_next;
    logic [1:0]         code_r;
    logic [1:0]         code_next;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   run_cnt;
    logic               conflict;

    assign conflict = sensor_conflict(f_uh_hl, f_uh_ll);

    // Both counters restart whenever their state is (re)entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HOLDOFF;
            code_r   <= FC_NONE;
            hold_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            state_r  <= state_next;
            code_r   <= code_next;
            hold_cnt <= (state_r == HOLDOFF && state_next == HOLDOFF) ? hold_cnt + CNT_W'(1) : '0;
            run_cnt  <= (state_r == RUN && state_next == RUN) ? run_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state_r;
        code_next  = code_r;
        case (state_r)
            HOLDOFF: begin
                if (conflict) begin
                    state_next = FAULT;
                    code_next  = FC_SENSOR;
                end else if (hold_cnt == CNT_W'(MIN_OFF_CYC - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (conflict) begin
                    state_next = FAULT;
                    code_next  = FC_SENSOR;
                end else if (enable && f_ug_ll && !f_uh_ll) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // A conflict outranks the timeout, so a coincident pair reports SENSOR.
                if (conflict) begin
                    state_next = FAULT;
                    code_next  = FC_SENSOR;
                end else if (run_cnt == CNT_W'(MAX_RUN_CYC - 1)) begin
                    state_next = FAULT;
                    code_next  = FC_TIMEOUT;
                end else if (f_uh_hl || !f_ug_ll || !enable) begin
                    state_next = HOLDOFF;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_next = HOLDOFF;
                    code_next  = FC_NONE;
                end
            end
            default: begin
                state_next = HOLDOFF;
                code_next  = FC_NONE;
            end
        endcase
    end

    always_comb begin
        pump       = (state_r == RUN);
        fault      = (state_r == FAULT);
        fault_code = code_r;
        state      = state_r;
    end

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer: the driver schedules expected outputs per
// cycle in a queue, and a negedge monitor pops and compares them.
module tb_pump_sequencer;
    import pump_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ug_ll = 1'b1;
    logic       uh_hl = 1'b0;
    logic       uh_ll = 1'b0;
    logic       enable = 1'b1;
    logic       fault_clr = 1'b0;
    logic       pump;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    pump_sequencer #(
        .DEBOUNCE_CYC (4),
        .MIN_OFF_CYC  (8),
        .MAX_RUN_CYC  (32),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ug_ll      (ug_ll),
        .uh_hl      (uh_hl),
        .uh_ll      (uh_ll),
        .enable     (enable),
        .fault_clr  (fault_clr),
        .pump       (pump),
        .fault      (fault),
        .fault_code (fault_code),
        .state      (state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: expected {pump, fault, fault_code, state} keyed by cycle
    logic [6:0] exp_q[$];
    int         exp_cyc_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    logic [6:0] ev;
    logic [6:0] act;
    int         ec;
    string      nm;

    always @(negedge clk) begin
        act = {pump, fault, fault_code, state};
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            ev = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (ec != cyc) begin
                n_fail++;
                $display("FAIL %s: checked at cycle %0d, was due at cycle %0d", nm, cyc, ec);
            end else if (act !== ev) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got pump=%b fault=%b code=%b state=%0d, want pump=%b fault=%b code=%b state=%0d",
                         nm, cyc, act[6], act[5], act[4:3], act[2:0], ev[6], ev[5], ev[4:3], ev[2:0]);
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int k, input string name, input logic p, input logic f,
                             input logic [1:0] c, input logic [2:0] s);
        exp_cyc_q.push_back(cyc + k);
        exp_q.push_back({p, f, c, s});
        name_q.push_back(name);
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
    endtask

    initial begin
        // reset
        tick(1);
        expect_at(1, "reset_values", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        tick(2);
        rst = 1'b0;

        // startup: edges counted from release
        expect_at(1, "startup_holdoff_e1", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(7, "startup_holdoff_e7", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(8, "startup_idle_e8",    1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(9, "startup_run_e9",     1'b1, 1'b0, FC_NONE, RUN);
        tick(10);

        // glitch rejection: 3-cycle pulse on uh_hl
        uh_hl = 1'b1;
        expect_at(8, "glitch_still_run", 1'b1, 1'b0, FC_NONE, RUN);
        tick(3);
        uh_hl = 1'b0;
        tick(5);

        // normal stop: low switch wet, then high switch wet
        uh_ll = 1'b1;
        tick(8);
        uh_hl = 1'b1;
        expect_at(6, "stop_edge6_run",     1'b1, 1'b0, FC_NONE, RUN);
        expect_at(7, "stop_edge7_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        tick(7);
        uh_hl = 1'b0;
        uh_ll = 1'b0;
        expect_at(7, "minoff_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(8, "minoff_idle",    1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(9, "minoff_rerun",   1'b1, 1'b0, FC_NONE, RUN);
        tick(9);

        // timeout: pump on for exactly 32 cycles
        expect_at(31, "timeout_last_run", 1'b1, 1'b0, FC_NONE, RUN);
        expect_at(32, "timeout_fault",    1'b0, 1'b1, FC_TIMEOUT, FAULT);
        tick(32);
        expect_at(3, "timeout_code_held", 1'b0, 1'b1, FC_TIMEOUT, FAULT);
        tick(3);
        expect_at(1,  "timeout_clr_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(9,  "timeout_clr_idle",    1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(10, "timeout_clr_run",     1'b1, 1'b0, FC_NONE, RUN);
        pulse_clr();
        tick(9);

        // source dry
        ug_ll = 1'b0;
        expect_at(6, "dry_edge6_run",     1'b1, 1'b0, FC_NONE, RUN);
        expect_at(7, "dry_edge7_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        tick(7);

        // fault_clr outside FAULT must not disturb the holdoff count
        expect_at(7, "clr_ignored_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(8, "clr_ignored_idle",    1'b0, 1'b0, FC_NONE, IDLE);
        pulse_clr();
        tick(7);

        // sensor conflict from IDLE
        enable = 1'b0;
        ug_ll  = 1'b1;
        uh_hl  = 1'b1;
        expect_at(6, "conflict_pre_idle", 1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(7, "conflict_fault",    1'b0, 1'b1, FC_SENSOR, FAULT);
        tick(7);
        expect_at(1, "conflict_clr_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(2, "conflict_refault",     1'b0, 1'b1, FC_SENSOR, FAULT);
        pulse_clr();
        tick(1);

        // remove the conflict, clear, and return to RUN
        uh_hl = 1'b0;
        expect_at(7, "conflict_code_held", 1'b0, 1'b1, FC_SENSOR, FAULT);
        tick(7);
        expect_at(1, "conflict_gone_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        pulse_clr();
        enable = 1'b1;
        expect_at(8, "recover_idle", 1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(9, "recover_run",  1'b1, 1'b0, FC_NONE, RUN);
        tick(11);

        // reset mid-RUN
        rst = 1'b1;
        expect_at(1, "midrun_reset", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        tick(1);
        rst = 1'b0;
        expect_at(1, "postreset_holdoff", 1'b0, 1'b0, FC_NONE, HOLDOFF);
        expect_at(8, "postreset_idle",    1'b0, 1'b0, FC_NONE, IDLE);
        expect_at(9, "postreset_run",     1'b1, 1'b0, FC_NONE, RUN);
        tick(11);

        // final report
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, due at cycle %0d, now %0d", nm, ec, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
